secure_sram_responder: RTL and testbench
========================================

Name: secure_sram_responder

Overview:
- Memory-side responder of the host cs/we/addr/wdata/rdata/ready protocol used by the secure SRAM benches.
- Stores words XOR-encrypted with an address-dependent keystream derived from the TRNG keys loaded via dcr.
- Scrambles physical addresses.
- Memory persists across reset, so a read after reset with a different key returns garbage.

Parameters:
ADDR_W, 14, host address width; memory depth is 2**ADDR_W words
DATA_W, 52, word width; keystream logic is fixed at 52 bits and DATA_W must equal 52

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
dcr  input  1  key-load request, sampled only in IDLE
trng_a_in  input  64  key A
trng_d_in  input  32  key D
cs  input  1  access request, held by host until ready seen
we  input  1  1=write, 0=read; sampled with cs
addr  input  ADDR_W  logical address
wdata  input  DATA_W  plaintext write data
rdata  output  DATA_W  decrypted read data
ready  output  1  access complete; held until cs=0
err  output  1  access attempted with no valid key; valid while ready=1
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; ready=0, rdata=0, err=0, busy=0.
  - key_a=0, key_d=0, key_valid=0.
  - Memory is NOT cleared unless the optional feature below is compiled in.
  - Reset wins over any in-flight access; the access is aborted and no memory write occurs.
- States: IDLE, KEYLOAD, KEYGEN, ACCESS, DONE (plus ZERO if the optional feature is compiled in).
- IDLE:
  - dcr=1 -> KEYLOAD. dcr has priority over cs.
  - else cs=1 -> capture we, addr, wdata into registers; go to KEYGEN.
- KEYLOAD:
  - Every cycle: key_a<=trng_a_in, key_d<=trng_d_in, key_valid<=1.
  - Stays while dcr=1; dcr=0 -> IDLE. The last cycle with dcr=1 defines the key.
- KEYGEN (one cycle): register the keystream ks and the physical address pa.
  - pa = addr ^ key_d[ADDR_W-1:0].
  - t = {addr, addr, addr, addr[9:0]} ^ key_a[51:0].
  - r = key_d[5:0] mod 52.
  - ks = rotl52(t, r) ^ {key_a[63:52], key_d[31:0], 8'h00}.
- ACCESS (one cycle):
  - key_valid=1 and we=1: mem[pa] <= wdata ^ ks.
  - key_valid=1 and we=0: synchronous read of mem[pa].
  - key_valid=0: no memory access; err_next=1.
- DONE:
  - ready=1. For a valid read, rdata = mem_q ^ ks. For a write or an error, rdata = 0. err = err_next.
  - Outputs stay stable while cs=1.
  - cs=0 -> IDLE; on that same edge ready<=0, err<=0. rdata holds its last value.
- Latency: cs sampled at edge N in IDLE -> ready=1 after edge N+3. Next request is accepted no earlier than 1 cycle after cs drops.
- Inputs changing while busy are ignored:
  - dcr is ignored outside IDLE; a dcr still high on return to IDLE enters KEYLOAD.
  - addr, we and wdata are used only as captured in IDLE.
- Write-then-read of the same address with the same keys returns the original wdata exactly.
- Physical address wraps modulo 2**ADDR_W; no out-of-range case exists.

Optional Feature:
- SRAM_ZEROIZE_EN defined:
  - Reset releases into state ZERO, which writes 0 to every physical word, one word per cycle, over 2**ADDR_W cycles.
  - busy=1 and ready=0 throughout; cs and dcr are ignored; then IDLE.
  - A read of any unwritten word afterwards returns ks for that address.
- Not defined: reset leaves state IDLE directly; memory contents survive reset.

Test Plan:
- Key load and round trip:
  - Stimulus: dcr=1 for 10 cycles with A=64'hDEADBEEFCAFEBABE, D=32'h12345678; write addr 0..99 with (i*7+13)%256, then read addr 0..99.
  - Response: reads return 13, 20, 27, ... exactly; err=0.
- Persistence across reset (macro off):
  - Stimulus: write as above; pulse rst for 5 cycles; reload the same keys; read.
  - Response: 100/100 reads match the written values.
- Wrong key:
  - Stimulus: after the writes, reset and reload with A=0, D=32'h12345678; read addr 0..99.
  - Response: data differs from the plaintext and equals the bench model (mem ^ ks_wrong).
- Handshake timing:
  - Stimulus: cs=1 at edge N; hold cs high for 5 extra cycles.
  - Response: ready=1 after edge N+3; ready and rdata stable while cs=1; ready=0 one edge after cs=0; busy=0 in IDLE.
- No key and mid-access reset:
  - Stimulus: after reset, write addr 5 = 52'h1 without dcr.
  - Response: ready=1, err=1, rdata=0.
  - Stimulus: reload keys; assert rst in ACCESS during a write to addr 7; reload keys; read addr 7.
  - Response: read does not return the aborted write data.
- SRAM_ZEROIZE_EN:
  - Stimulus: pulse rst; count busy cycles; load keys; read addr 3.
  - Response: busy high for exactly 16384 cycles; read returns ks(3) per the bench model.

Source files
------------

// File: rtl/secure_sram_responder.sv
// rtl/secure_sram_responder.sv - encrypted, address-scrambled SRAM responder; optional SRAM_ZEROIZE_EN clears memory after reset
module secure_sram_responder #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 52
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcr,
  input  logic [63:0]       trng_a_in,
  input  logic [31:0]       trng_d_in,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, KEYLOAD, KEYGEN, ACCESS, DONE
`ifdef SRAM_ZEROIZE_EN
    , ZERO
`endif
  } state_t;

`ifdef SRAM_ZEROIZE_EN
  localparam state_t RST_STATE = ZERO;
  logic [ADDR_W-1:0] zcnt;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t            state, state_d;
  logic [63:0]       key_a;
  logic [31:0]       key_d;
  logic              key_valid;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q, pa_q, pa_d;
  logic [DATA_W-1:0] wdata_q, ks_q, ks_d, mem_q;
  logic [51:0]       t;
  logic [5:0]        r;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Rotate a 52-bit word left by n (n < 52); the doubled word makes the wrap free.
  function automatic logic [51:0] rotl52(input logic [51:0] v, input logic [5:0] n);
    logic [103:0] d;
    d = {v, v} << n;
    return d[103:52];
  endfunction

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (dcr) state_d = KEYLOAD; else if (cs) state_d = KEYGEN;
      KEYLOAD: if (!dcr) state_d = IDLE;
      KEYGEN:  state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    if (ready && !cs) state_d = IDLE;
`ifdef SRAM_ZEROIZE_EN
      ZERO:    if (zcnt == '1) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Address-dependent keystream and scrambled physical address from the captured request.
  always_comb begin
    t    = {addr_q, addr_q, addr_q, addr_q[9:0]} ^ key_a[51:0];
    r    = key_d[5:0] % 6'd52;
    ks_d = rotl52(t, r) ^ {key_a[63:52], key_d, 8'h00};
    pa_d = addr_q ^ key_d[ADDR_W-1:0];
  end

  // Key registers, request capture, keystream pipeline and host-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_a     <= '0;
      key_d     <= '0;
      key_valid <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!dcr && cs) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
        end
        KEYLOAD: begin
          key_a     <= trng_a_in;
          key_d     <= trng_d_in;
          key_valid <= 1'b1;
        end
        KEYGEN: begin
          ks_q <= ks_d;
          pa_q <= pa_d;
        end
        ACCESS: begin
          err_q <= !key_valid;
          if (key_valid && !we_q) mem_q <= mem[pa_q];
        end
        DONE: begin
          if (!ready) begin
            ready <= 1'b1;
            err   <= err_q;
            rdata <= (!err_q && !we_q) ? (mem_q ^ ks_q) : '0;
          end else if (!cs) begin
            ready <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Single memory write port shared by host writes and zeroization.
  always_comb begin
    mem_we = !rst && (state == ACCESS) && key_valid && we_q;
    mem_wa = pa_q;
    mem_wd = wdata_q ^ ks_q;
`ifdef SRAM_ZEROIZE_EN
    if (!rst && state == ZERO) begin
      mem_we = 1'b1;
      mem_wa = zcnt;
      mem_wd = '0;
    end
`endif
  end

`ifdef SRAM_ZEROIZE_EN
  // Zeroization sweep counter, one physical word per cycle.
  always_ff @(posedge clk) begin
    if (rst)                zcnt <= '0;
    else if (state == ZERO) zcnt <= zcnt + 1'b1;
  end
`endif

  // Memory array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_secure_sram_responder.sv
// tb/tb_secure_sram_responder.sv - table-driven scoreboard bench for secure_sram_responder
module tb_secure_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0, dcr = 1'b0, cs = 1'b0, we = 1'b0;
  logic [63:0] trng_a_in = '0;
  logic [31:0] trng_d_in = '0;
  logic [13:0] addr = '0;
  logic [51:0] wdata = '0;
  logic [51:0] rdata;
  logic        ready, err, busy;

  always #5 clk = ~clk;

  secure_sram_responder #(.ADDR_W(14), .DATA_W(52)) dut (
    .clk(clk), .rst(rst), .dcr(dcr), .trng_a_in(trng_a_in), .trng_d_in(trng_d_in),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .err(err), .busy(busy)
  );

  typedef struct { logic w; logic [13:0] a; logic [51:0] d; logic [51:0] exp_rd; logic exp_err; } vec_t;
  typedef struct { logic [51:0] rd; logic e; } exp_t;

  int tests = 0, fails = 0;
  exp_t sb[$];
  logic [51:0] got[$];

  localparam logic [63:0] KEY_A1 = 64'hDEADBEEFCAFEBABE;
  localparam logic [31:0] KEY_D1 = 32'h12345678;

  // Reference model: current keys and physical memory image.
  logic [63:0] ma = '0;
  logic [31:0] md = '0;
  logic        mvalid = 1'b0;
  logic [51:0] phys [int];

  function automatic logic [51:0] m_ks(input logic [13:0] a);
    logic [51:0] tt;
    int rr;
    tt = {a, a, a, a[9:0]} ^ ma[51:0];
    rr = int'(md[5:0]);
    while (rr >= 52) rr -= 52;
    for (int i = 0; i < rr; i++) tt = {tt[50:0], tt[51]};
    return tt ^ {ma[63:52], md, 8'h00};
  endfunction

  function automatic int m_pa(input logic [13:0] a);
    return int'(a ^ md[13:0]);
  endfunction

  function automatic logic [51:0] m_read(input logic [13:0] a);
    if (phys.exists(m_pa(a))) return phys[m_pa(a)] ^ m_ks(a);
    return m_ks(a);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int n, output int busy_cycles);
    @(negedge clk);
    rst = 1'b1; cs = 1'b0; dcr = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    mvalid = 1'b0; ma = '0; md = '0;
    busy_cycles = 0;
`ifdef SRAM_ZEROIZE_EN
    phys.delete();
    while (busy && busy_cycles < 20000) begin
      busy_cycles++;
      @(negedge clk);
    end
`endif
  endtask

  task automatic load_keys(input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    dcr = 1'b1; trng_a_in = a; trng_d_in = d;
    repeat (10) @(negedge clk);
    dcr = 1'b0;
    @(negedge clk);
    ma = a; md = d; mvalid = 1'b1;
  endtask

  task automatic access(input logic w, input logic [13:0] a, input logic [51:0] d,
                        output logic [51:0] rd, output logic e);
    int n;
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++; fails++;
      $display("FAIL access_timeout: ready=%b expected 1 (addr %0d)", ready, a);
    end
    rd = rdata; e = err;
    cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_table(input vec_t tbl[$], input string nm);
    got.delete();
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t ex;
      logic [51:0] rd;
      logic e;
      ex.rd = tbl[i].exp_rd; ex.e = tbl[i].exp_err;
      sb.push_back(ex);
      if (tbl[i].w && mvalid) phys[m_pa(tbl[i].a)] = tbl[i].d ^ m_ks(tbl[i].a);
      access(tbl[i].w, tbl[i].a, tbl[i].d, rd, e);
      ex = sb.pop_front();
      check($sformatf("%s[%0d].rdata", nm, i), 64'(rd), 64'(ex.rd));
      check($sformatf("%s[%0d].err", nm, i), 64'(e), 64'(ex.e));
      got.push_back(rd);
    end
  endtask

  initial begin
    vec_t wr_tbl[$], rd_tbl[$], wk_tbl[$];
    int bc, ndiff;
    logic [51:0] rd, hold;
    logic e;

    for (int i = 0; i < 100; i++) begin
      vec_t v;
      v.w = 1'b1; v.a = 14'(i); v.d = 52'((i * 7 + 13) % 256); v.exp_rd = '0; v.exp_err = 1'b0;
      wr_tbl.push_back(v);
      v.w = 1'b0; v.d = '0; v.exp_rd = 52'((i * 7 + 13) % 256);
      rd_tbl.push_back(v);
    end

    do_reset(3, bc);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_err", 64'(err), 64'd0);
`ifdef SRAM_ZEROIZE_EN
    check("zeroize_busy_cycles", 64'(bc), 64'd16384);
    load_keys(KEY_A1, KEY_D1);
    access(1'b0, 14'd3, '0, rd, e);
    check("zeroize_read3", 64'(rd), 64'(m_read(14'd3)));
    check("zeroize_read3_err", 64'(e), 64'd0);
    apply_table(wr_tbl, "rt_write");
    apply_table(rd_tbl, "rt_read");
`else
    check("reset_busy", 64'(busy), 64'd0);

    access(1'b1, 14'd5, 52'h1, rd, e);
    check("nokey_err", 64'(e), 64'd1);
    check("nokey_rdata", 64'(rd), 64'd0);

    load_keys(KEY_A1, KEY_D1);
    apply_table(wr_tbl, "rt_write");
    apply_table(rd_tbl, "rt_read");

    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 14'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("hs_ready_edge%0d", k), 64'(ready), 64'd0);
    end
    @(negedge clk);
    check("hs_ready_edge4", 64'(ready), 64'd1);
    check("hs_rdata", 64'(rdata), 64'd13);
    hold = rdata;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hs_stable%0d", k), {63'd0, ready && (rdata === hold)}, 64'd1);
    end
    cs = 1'b0;
    @(negedge clk);
    check("hs_ready_drop", 64'(ready), 64'd0);
    check("hs_busy_idle", 64'(busy), 64'd0);
    check("hs_rdata_hold", 64'(rdata), 64'd13);

    do_reset(5, bc);
    load_keys(KEY_A1, KEY_D1);
    apply_table(rd_tbl, "persist");

    do_reset(5, bc);
    load_keys(64'd0, KEY_D1);
    for (int i = 0; i < 100; i++) begin
      vec_t v;
      v.w = 1'b0; v.a = 14'(i); v.d = '0; v.exp_rd = m_read(14'(i)); v.exp_err = 1'b0;
      wk_tbl.push_back(v);
    end
    apply_table(wk_tbl, "wrongkey");
    ndiff = 0;
    for (int i = 0; i < 100; i++) if (got[i] !== 52'((i * 7 + 13) % 256)) ndiff++;
    check("wrongkey_differs", 64'(ndiff), 64'd100);

    do_reset(5, bc);
    load_keys(KEY_A1, KEY_D1);
    access(1'b1, 14'd7, 52'h0000_0000_5A5A5, rd, e);
    phys[m_pa(14'd7)] = 52'h0000_0000_5A5A5 ^ m_ks(14'd7);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 14'd7; wdata = 52'hF_0F0F_0F0F_0F0F;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_in_access", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    check("abort_ready", 64'(ready), 64'd0);
    do_reset(4, bc);
    load_keys(KEY_A1, KEY_D1);
    access(1'b0, 14'd7, '0, rd, e);
    check("abort_read7", 64'(rd), 64'(m_read(14'd7)));
    check("abort_not_new", {63'd0, rd !== 52'hF_0F0F_0F0F_0F0F}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
